regfile_wb_ctrl: RTL
====================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side initiator for the CPU register file. Accepts results from the ALU (buffered) and the LSU (priority).
//  Arbitrates them onto the single regfile write port (rf_we/rf_rd_addr/rf_rd_data).
//  Keeps a per-register busy scoreboard so decode stalls on pending destinations.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  REGISTER_WIDTH       32  data width of one architectural register
//  REGISTER_ADDR_WIDTH  5   register index width (2**N registers; x0 hardwired zero)
//  ALU_FIFO_DEPTH       2   ALU result buffer entries (power of 2, >=2)
//  LSU_BURST_MAX        4   consecutive LSU grants allowed while ALU data waits
// PORTS
//  cpu_clk      in   1    clock, all state on rising edge
//  cpu_rst_n    in   1    asynchronous active-low reset
//  issue_valid  in   1    decode issues an instruction writing issue_rd
//  issue_rd     in   AW   destination register of issuing instruction
//  issue_ready  out  1    issue accepted this cycle (combinational)
//  chk_rs1_addr in   AW   decode source 1 query
//  chk_rs2_addr in   AW   decode source 2 query
//  rs1_busy     out  1    busy[chk_rs1_addr] (0 for x0)
//  rs2_busy     out  1    busy[chk_rs2_addr] (0 for x0)
//  alu_valid/alu_ready  in/out 1  ALU result handshake
//  alu_rd       in   AW   ALU destination
//  alu_data     in   W    ALU result
//  lsu_valid/lsu_ready  in/out 1  load result handshake
//  lsu_rd       in   AW   load destination
//  lsu_data     in   W    load data
//  rf_we        out  1    regfile write enable (registered)
//  rf_rd_addr   out  AW   regfile write address (registered)
//  rf_rd_data   out  W    regfile write data (registered)
// BEHAVIOUR
//  Reset: one clock (cpu_clk); reset is asynchronous and active-low (cpu_rst_n).
//   While low: busy=0, FIFO empty, burst count 0, rf_we=0, rf_rd_addr=0, rf_rd_data=0.
//   Release mid-operation discards all in-flight results.
//  Handshake: transfer when valid&&ready at a rising edge. Payload is held stable while valid&&!ready.
//  Scoreboard busy[2**AW-1:0]:
//   - issue_ready = !busy[issue_rd] || issue_rd==0.
//   - Set busy[issue_rd] on issue transfer when rd!=0.
//   - Clear busy[rf_rd_addr] at the edge where rf_we==1, i.e. when the regfile commits.
//   - Set and clear of the same rd cannot coincide, because issue_ready blocks a busy rd.
//  ALU path: alu_ready = !fifo_full; push on transfer.
//  Grant, one winner per cycle:
//   - LSU if lsu_valid && !(burst==LSU_BURST_MAX && fifo_nonempty).
//   - Else the FIFO head if non-empty.
//   - Else the ALU directly (bypass) if alu_valid; a bypassed entry is not pushed.
//   - lsu_ready = LSU grant.
//  burst: +1 on LSU grant while fifo_nonempty; reset to 0 on any ALU/FIFO grant or when the FIFO is empty.
//   Saturates at LSU_BURST_MAX, after which the FIFO head wins one cycle.
//  Output register loads the winner: rf_we=1 for exactly one cycle per result; else rf_we=0.
//   rd==0 results are consumed but produce rf_we=0.
//  Latency: accept at edge N -> rf_we high after edge N; regfile updated and busy cleared at edge N+1.
//  FIFO: push and pop in the same cycle are legal when not full; the count is unchanged. Full blocks the push.
// STRUCTURE
//  Shared package cpu_pkg: REGISTER_WIDTH/REGISTER_ADDR_WIDTH constants; typedef wb_pkt_t {rd, data}.
//  Sub-module wb_fifo: synchronous FIFO of wb_pkt_t, depth ALU_FIFO_DEPTH, full/empty/count outputs.
//  Top holds the scoreboard, burst counter, grant logic and output register.
// TESTING
//  1. Issue rd=5, ALU {5,0xDEAD} alone -> rf_we=1, addr 5, data 0xDEAD next cycle; busy[5] 1->0 one edge later.
//  2. ALU {3,0x11} and LSU {4,0x22} same cycle -> LSU written first, ALU buffered and written the following cycle.
//  3. LSU valid 8 cycles with 1 ALU entry queued -> 4 LSU writes, 1 ALU write, LSU resumes; no result lost.
//  4. Issue rd=7 twice back-to-back -> 2nd stalls (issue_ready=0) until the rd=7 write commits; rd=0 issue never stalls.
//  5. Fill FIFO with LSU valid, then ALU valid -> alu_ready=0; a result to rd=0 gives rf_we=0 and is consumed.
//  6. Assert cpu_rst_n=0 mid-burst, async to clock -> all outputs and busy zero immediately; clean restart after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU write-back types: register geometry and the packet carried
// from the execute/memory stages to the register file write port.
package cpu_pkg;

  localparam int REGISTER_WIDTH      = 32;
  localparam int REGISTER_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [REGISTER_ADDR_WIDTH-1:0] rd;
    logic [REGISTER_WIDTH-1:0]      data;
  } wb_pkt_t;

  function automatic wb_pkt_t make_pkt(input logic [REGISTER_ADDR_WIDTH-1:0] rd,
                                       input logic [REGISTER_WIDTH-1:0]      data);
    wb_pkt_t p;
    p.rd   = rd;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back packets; buffers ALU results while
// the LSU owns the register file write port.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  wb_pkt_t                  i_din,
  input  logic                     i_pop,
  output wb_pkt_t                  o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  wb_pkt_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Full blocks a push even if a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates LSU (priority) and buffered
// ALU results onto the single write port and tracks pending destinations.
module regfile_wb_ctrl
  import cpu_pkg::*;
#(
  parameter int REGISTER_WIDTH      = cpu_pkg::REGISTER_WIDTH,
  parameter int REGISTER_ADDR_WIDTH = cpu_pkg::REGISTER_ADDR_WIDTH,
  parameter int ALU_FIFO_DEPTH      = 2,
  parameter int LSU_BURST_MAX       = 4
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst_n,
  input  logic                           issue_valid,
  input  logic [REGISTER_ADDR_WIDTH-1:0] issue_rd,
  output logic                           issue_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0] chk_rs1_addr,
  input  logic [REGISTER_ADDR_WIDTH-1:0] chk_rs2_addr,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REGISTER_WIDTH-1:0]      alu_data,
  input  logic                           lsu_valid,
  output logic                           lsu_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [REGISTER_WIDTH-1:0]      lsu_data,
  output logic                           rf_we,
  output logic [REGISTER_ADDR_WIDTH-1:0] rf_rd_addr,
  output logic [REGISTER_WIDTH-1:0]      rf_rd_data
);

  localparam int NREG = 2 ** REGISTER_ADDR_WIDTH;
  localparam int BW   = $clog2(LSU_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(LSU_BURST_MAX);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  logic [NREG-1:0]                    r_busy;
  logic [NREG-1:0]                    w_busy_nxt;
  logic [BW-1:0]                      r_burst;
  logic                               r_rf_we;
  logic [REGISTER_ADDR_WIDTH-1:0]     r_rf_rd_addr;
  logic [REGISTER_WIDTH-1:0]          r_rf_rd_data;

  wb_pkt_t                            w_alu_pkt;
  wb_pkt_t                            w_lsu_pkt;
  wb_pkt_t                            w_fifo_head;
  wb_pkt_t                            w_win_pkt;
  logic                               w_fifo_full;
  logic                               w_fifo_empty;
  logic [$clog2(ALU_FIFO_DEPTH):0]    w_fifo_count;
  logic                               w_fifo_nonempty;
  logic                               w_lsu_hold;
  logic                               w_gnt_lsu;
  logic                               w_gnt_fifo;
  logic                               w_gnt_alu;
  logic                               w_win_vld;
  logic                               w_alu_push;
  logic                               w_issue_xfer;

  assign w_alu_pkt       = make_pkt(alu_rd, alu_data);
  assign w_lsu_pkt       = make_pkt(lsu_rd, lsu_data);
  assign w_fifo_nonempty = (w_fifo_count != '0);

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  assign issue_ready  = !r_busy[issue_rd] || (issue_rd == '0);
  assign w_issue_xfer = issue_valid && issue_ready && (issue_rd != '0);
  assign rs1_busy     = r_busy[chk_rs1_addr] && (chk_rs1_addr != '0);
  assign rs2_busy     = r_busy[chk_rs2_addr] && (chk_rs2_addr != '0);

  // Clear and set never target the same rd: issue_ready holds off a busy rd.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_we)      w_busy_nxt[r_rf_rd_addr] = 1'b0;
    if (w_issue_xfer) w_busy_nxt[issue_rd]     = 1'b1;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) r_busy <= '0;
    else            r_busy <= w_busy_nxt;
  end

  // ---------------------------------------------------------------------
  // Grant: LSU first unless its burst has starved a waiting ALU result,
  // then the buffered ALU head, then a direct ALU bypass.
  // ---------------------------------------------------------------------
  assign w_lsu_hold = (r_burst == BURST_MAX) && w_fifo_nonempty;

  always_comb begin
    w_gnt_lsu  = lsu_valid && !w_lsu_hold;
    w_gnt_fifo = !w_gnt_lsu && w_fifo_nonempty;
    w_gnt_alu  = !w_gnt_lsu && !w_fifo_nonempty && alu_valid;
    w_win_vld  = w_gnt_lsu || w_gnt_fifo || w_gnt_alu;
    w_win_pkt  = w_alu_pkt;
    if (w_gnt_lsu)       w_win_pkt = w_lsu_pkt;
    else if (w_gnt_fifo) w_win_pkt = w_fifo_head;
  end

  assign lsu_ready  = w_gnt_lsu;
  assign alu_ready  = !w_fifo_full;
  assign w_alu_push = alu_valid && alu_ready && !w_gnt_alu;

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .i_clk   (cpu_clk),
    .i_rst_n (cpu_rst_n),
    .i_push  (w_alu_push),
    .i_din   (w_alu_pkt),
    .i_pop   (w_gnt_fifo),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Burst counts LSU wins only while an ALU result is actually waiting.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_burst <= '0;
    end else if (w_gnt_lsu && w_fifo_nonempty) begin
      if (r_burst != BURST_MAX) r_burst <= r_burst + BURST_ONE;
    end else if (w_gnt_fifo || w_gnt_alu || w_fifo_empty) begin
      r_burst <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Write-port register; results to x0 are consumed without a write.
  // ---------------------------------------------------------------------
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_rd_addr <= '0;
      r_rf_rd_data <= '0;
    end else if (w_win_vld && (w_win_pkt.rd != '0)) begin
      r_rf_we      <= 1'b1;
      r_rf_rd_addr <= w_win_pkt.rd;
      r_rf_rd_data <= w_win_pkt.data;
    end else begin
      r_rf_we      <= 1'b0;
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_rd_addr = r_rf_rd_addr;
  assign rf_rd_data = r_rf_rd_data;

endmodule
